// File: rtl/rpn_issue_unit_if.sv
// rtl/rpn_issue_unit_if.sv - instruction, ALU, result and status signals of the RPN issue unit
interface rpn_issue_unit_if #(
  parameter int N  = 8,
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [N-1:0]  in_data;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_input_data;
  logic [N-1:0]  alu_output_data;
  logic          alu_overflow;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic          res_overflow;
  logic [2:0]    res_opcode;
  logic [DW-1:0] depth;
  logic          err;
  logic [1:0]    err_code;
  logic          busy;

  // master: instruction source, ALU and result sink; slave: the issue unit
  modport master (
    output in_valid, in_opcode, in_data, alu_output_data, alu_overflow, res_ready,
    input  in_ready, alu_opcode, alu_input_data, res_valid, res_data, res_overflow,
           res_opcode, depth, err, err_code, busy
  );

  modport slave (
    input  in_valid, in_opcode, in_data, alu_output_data, alu_overflow, res_ready,
    output in_ready, alu_opcode, alu_input_data, res_valid, res_data, res_overflow,
           res_opcode, depth, err, err_code, busy
  );
endinterface

// File: rtl/rpn_issue_unit.sv
// rtl/rpn_issue_unit.sv - buffers RPN instructions, checks modelled stack depth, issues one-cycle ALU pulses
module rpn_issue_unit #(
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STACK_SIZE = 201,
  parameter int DW         = $clog2(STACK_SIZE + 1)
) (
  input logic           clk,
  input logic           rst,
  rpn_issue_unit_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX     = DW'(STACK_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    fifo_op_q   [FIFO_DEPTH];
  logic [N-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty, wr_en, rd_en;
  logic [2:0]    head_op;
  logic [N-1:0]  head_data;

  logic [2:0]    alu_op_q, alu_op_d;
  logic [N-1:0]  alu_data_q, alu_data_d;
  logic          res_valid_q, res_valid_d;
  logic [N-1:0]  res_data_q, res_data_d;
  logic          res_ovf_q, res_ovf_d;
  logic [2:0]    res_op_q, res_op_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          new_err;
  logic [1:0]    new_err_code;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign wr_en      = bus.in_valid && !fifo_full;
  assign head_op    = fifo_op_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_op_q[wr_ptr_q]   <= bus.in_opcode;
      fifo_data_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_en        = 1'b0;
    alu_op_d     = alu_op_q;
    alu_data_d   = alu_data_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_ovf_d    = res_ovf_q;
    res_op_d     = res_op_q;
    depth_d      = depth_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    new_err      = 1'b0;
    new_err_code = 2'b00;

    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!head_op[2]) begin
            rd_en        = 1'b1;
            new_err      = 1'b1;
            new_err_code = 2'b11;
          end else if (((head_op == OP_ADD || head_op == OP_MUL) && depth_q < DW'(2)) ||
                       (head_op == OP_POP && depth_q == '0)) begin
            rd_en        = 1'b1;
            new_err      = 1'b1;
            new_err_code = 2'b01;
          end else if (head_op == OP_PUSH && depth_q == DEPTH_MAX) begin
            rd_en        = 1'b1;
            new_err      = 1'b1;
            new_err_code = 2'b10;
          end else if (head_op != OP_PUSH && res_valid_q && !bus.res_ready) begin
            // result slot still owned by the consumer: hold the head until it drains
            rd_en = 1'b0;
          end else begin
            rd_en      = 1'b1;
            alu_op_d   = head_op;
            alu_data_d = (head_op == OP_PUSH) ? head_data : '0;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (alu_op_q != OP_PUSH) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.alu_output_data;
          res_ovf_d   = (alu_op_q == OP_POP) ? 1'b0 : bus.alu_overflow;
          res_op_d    = alu_op_q;
        end
        if (alu_op_q == OP_PUSH)     depth_d = depth_q + DW'(1);
        else if (alu_op_q == OP_POP) depth_d = depth_q - DW'(1);
        alu_op_d   = OP_NOP;
        alu_data_d = '0;
        state_d    = S_GAP;
      end
      S_GAP: begin
        alu_op_d   = OP_NOP;
        alu_data_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (new_err && !err_q) begin
      err_d      = 1'b1;
      err_code_d = new_err_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_op_q    <= OP_NOP;
      alu_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_op_q    <= OP_NOP;
      depth_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_data_q  <= alu_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_op_q    <= res_op_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.in_ready       = !fifo_full;
  assign bus.alu_opcode     = alu_op_q;
  assign bus.alu_input_data = alu_data_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_overflow   = res_ovf_q;
  assign bus.res_opcode     = res_op_q;
  assign bus.depth          = depth_q;
  assign bus.err            = err_q;
  assign bus.err_code       = err_code_q;
  assign bus.busy           = !fifo_empty || (state_q != S_IDLE);

endmodule
